// File: rtl/gpo_write_arbiter_if.sv
// gpo_write_arbiter_if: requester-side write bus and GPO status for gpo_write_arbiter
interface gpo_write_arbiter_if #(parameter int NUM_REQ = 4);
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [NUM_REQ*8-1:0] wr_data;
  logic [NUM_REQ*8-1:0] wr_mask;
  logic [7:0] gpo_out;
  logic busy;
  logic [GW-1:0] last_grant;
  modport master(output req, wr_data, wr_mask, input ack, gpo_out, busy, last_grant);
  modport slave(input req, wr_data, wr_mask, output ack, gpo_out, busy, last_grant);
endinterface

// File: rtl/gpo_write_arbiter.sv
// gpo_write_arbiter: round-robin masked writes into one 8-bit GPO register with post-write hold
module gpo_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int HOLD_CYCLES = 2,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input logic clk,
  input logic rst,
  gpo_write_arbiter_if.slave bus
);
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(HOLD_CYCLES + 1) > 1 ? $clog2(HOLD_CYCLES + 1) : 1;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_d;
  logic [GW-1:0] ptr, sel;
  logic [CW-1:0] cnt;
  logic found;
  logic [7:0] m, d;
  always_comb begin
    found = 1'b0;
    sel = ptr;
    for (int k = 0; k < NUM_REQ; k++)
      if (!found && bus.req[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        sel = GW'((int'(ptr) + k) % NUM_REQ);
      end
    m = bus.wr_mask[{sel, 3'b000} +: 8];
    d = bus.wr_data[{sel, 3'b000} +: 8];
    state_d = state == IDLE ? (found ? HOLD : IDLE) : (cnt == '0 ? IDLE : HOLD);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      bus.ack <= '0;
      bus.gpo_out <= RESET_VAL;
      bus.last_grant <= '0;
    end else begin
      state <= state_d;
      bus.ack <= '0;
      if (state == IDLE && found) begin
        bus.gpo_out <= (bus.gpo_out & ~m) | (d & m);
        bus.ack <= NUM_REQ'(1) << sel;
        bus.last_grant <= sel;
        ptr <= sel == GW'(NUM_REQ - 1) ? '0 : sel + 1'b1;
        cnt <= CW'(HOLD_CYCLES - 1);
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  assign bus.busy = state == HOLD;
endmodule

// File: tb/tb_gpo_write_arbiter.sv
// tb_gpo_write_arbiter: random and directed stimulus against a cooldown-based arbitration model
module tb_gpo_write_arbiter;
  localparam int N = 4;
  localparam int HOLD = 2;
  localparam logic [7:0] RV = 8'h00;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  bit auto_drop = 1;
  int grants[$];
  logic [7:0] m_gpo;
  logic [N-1:0] m_ack;
  int m_ptr, m_cool, m_last;
  gpo_write_arbiter_if #(.NUM_REQ(N)) bus();
  gpo_write_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HOLD), .RESET_VAL(RV)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // after a grant the arbiter ignores req for HOLD edges, then evaluates again
  task automatic model_edge();
    logic [7:0] md, mm;
    m_ack = '0;
    if (rst) begin
      m_gpo = RV; m_ptr = 0; m_cool = 0; m_last = 0;
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (m_ack == '0 && bus.req[j]) begin
          md = bus.wr_data[j*8 +: 8];
          mm = bus.wr_mask[j*8 +: 8];
          m_gpo = (m_gpo & ~mm) | (md & mm);
          m_ack[j] = 1'b1;
          m_last = j;
          m_ptr = (j + 1) % N;
          m_cool = HOLD;
        end
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ack", 32'(bus.ack), 32'(m_ack));
    chk("gpo", 32'(bus.gpo_out), 32'(m_gpo));
    chk("busy", 32'(bus.busy), 32'(m_cool > 0));
    chk("last", 32'(bus.last_grant), 32'(m_last));
    for (int i = 0; i < N; i++) if (bus.ack[i]) grants.push_back(i);
    if (auto_drop) bus.req = bus.req & ~bus.ack;
  endtask
  task automatic set_req(int i, logic [7:0] d, logic [7:0] m);
    bus.wr_data[i*8 +: 8] = d;
    bus.wr_mask[i*8 +: 8] = m;
    bus.req[i] = 1'b1;
  endtask
  task automatic wait_grants(int n, string tag);
    for (int c = 0; c < 40 && grants.size() < n; c++) tick();
    chk(tag, grants.size(), n);
  endtask
  initial begin
    bus.req = '0;
    bus.wr_data = '0;
    bus.wr_mask = '0;
    #1;
    bus.req = 4'hF;
    bus.wr_mask = '1;
    bus.wr_data = 32'hDEADBEEF;
    tick();
    chk("rst_ack", 32'(bus.ack), 0);
    tick();
    chk("rst_gpo", 32'(bus.gpo_out), 32'h00);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 0;
    bus.req = '0;
    tick();
    set_req(0, 8'hA5, 8'hFF);
    grants.delete();
    wait_grants(1, "t1_wait");
    chk("t1_gpo", 32'(bus.gpo_out), 32'hA5);
    chk("t1_ack", 32'(bus.ack), 32'h1);
    repeat (3) tick();
    set_req(2, 8'h0F, 8'hF0);
    grants.delete();
    wait_grants(1, "t2_wait");
    chk("t2_gpo", 32'(bus.gpo_out), 32'h05);
    chk("t2_ack", 32'(bus.ack), 32'h4);
    repeat (3) tick();
    set_req(3, 8'h77, 8'h00);
    grants.delete();
    wait_grants(1, "t3_wait");
    chk("t3_nomask", 32'(bus.gpo_out), 32'h05);
    repeat (3) tick();
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 * (i + 1) + i), 8'hFF);
    grants.delete();
    wait_grants(4, "order_wait");
    for (int i = 0; i < 4 && i < grants.size(); i++) chk($sformatf("order%0d", i), grants[i], i);
    chk("order_gpo", 32'(bus.gpo_out), 32'h43);
    repeat (3) tick();
    set_req(3, 8'h81, 8'hFF);
    set_req(0, 8'h18, 8'hFF);
    grants.delete();
    wait_grants(2, "wrap_wait");
    if (grants.size() == 2) begin
      chk("wrap0", grants[0], 0);
      chk("wrap1", grants[1], 3);
    end
    repeat (3) tick();
    auto_drop = 0;
    set_req(1, 8'h3C, 8'hFF);
    grants.delete();
    wait_grants(1, "rh_wait");
    chk("rh_gpo", 32'(bus.gpo_out), 32'h3C);
    rst = 1;
    tick();
    chk("rh_rst_gpo", 32'(bus.gpo_out), 32'h00);
    chk("rh_rst_busy", 32'(bus.busy), 0);
    rst = 0;
    tick();
    chk("rh_regrant", 32'(bus.ack), 32'h2);
    bus.req = '0;
    repeat (3) tick();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (bus.req[i] && bus.ack[i]) begin
          if ($urandom_range(1, 0) == 0) bus.req[i] = 1'b0;
          else set_req(i, 8'($urandom), 8'($urandom));
        end else if (!bus.req[i] && $urandom_range(3, 0) == 0) begin
          set_req(i, 8'($urandom), $urandom_range(7, 0) == 0 ? 8'h00 : 8'($urandom));
        end else if (bus.req[i] && $urandom_range(49, 0) == 0) begin
          bus.req[i] = 1'b0;
        end
      rst = $urandom_range(99, 0) == 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpo_write_arbiter.md
Name: gpo_write_arbiter

Overview:
- Shares one 8-bit general-purpose output register between NUM_REQ independent write requesters, e.g. core store path, debug port and boot sequencer.
- Arbitration is round-robin with a req/ack handshake and per-bit write masks.
- After every accepted write, the output is held stable for a programmable minimum number of cycles before the next grant.
- Sits between the bus/peripheral decode and the GPO pins. It replaces a bare output register.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- HOLD_CYCLES, 2, cycles spent in HOLD after each grant (>=1); output is stable for at least this long
- RESET_VAL, 8'h00, value of gpo_out after reset

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester write request; level, held until ack seen
- wr_data  input  NUM_REQ*8  requester i data in bits [8i+7:8i]
- wr_mask  input  NUM_REQ*8  requester i bit-enable in bits [8i+7:8i]; 1 = bit written
- ack  output  NUM_REQ  one-cycle pulse to the granted requester; registered
- gpo_out  output  8  general-purpose output register
- busy  output  1  high while in HOLD
- last_grant  output  $clog2(NUM_REQ)  index of most recently granted requester

Behaviour:
- Reset: one clk, reset is synchronous and active-high.
  - When rst is high at a rising edge: gpo_out=RESET_VAL, ack=0, busy=0, last_grant=0, state=IDLE, RR pointer=0, hold counter=0.
  - Reset overrides all other activity, including a write mid-HOLD. The aborted ack is never issued or is dropped; gpo_out returns to RESET_VAL.
- States: IDLE, HOLD.
- IDLE, sampled at each edge:
  - If req==0: remain IDLE, no change.
  - Else: select the first i with req[i]=1, searching ptr, ptr+1, ... mod NUM_REQ.
  - At that edge:
    - gpo_out <= (gpo_out & ~wr_mask[i]) | (wr_data[i] & wr_mask[i])
    - ack[i] <= 1
    - last_grant <= i
    - ptr <= (i+1) mod NUM_REQ
    - counter <= HOLD_CYCLES-1
    - busy <= 1
    - state <= HOLD
- HOLD:
  - req is ignored. ack is high only in the first HOLD cycle and cleared at the next edge.
  - Each edge: if counter==0, state <= IDLE and busy <= 0; else counter decrements.
  - HOLD lasts exactly HOLD_CYCLES cycles.
- Latency and throughput:
  - gpo_out and ack change in the cycle immediately after the sampling edge.
  - Back-to-back grants are spaced HOLD_CYCLES+1 cycles apart: HOLD_CYCLES cycles of HOLD plus one IDLE evaluation cycle.
- Handshake rules:
  - A requester holds req, wr_data and wr_mask stable from req assertion until it sees ack=1.
  - It deasserts req at the edge ending the ack cycle, or re-asserts with new data.
  - The arbiter never samples during HOLD, so a single request is never granted twice.
  - Deasserting req before ack withdraws the request; no write occurs.
- wr_mask==0 when granted: ack is still issued and HOLD still entered; gpo_out is unchanged.
- Requests arriving during HOLD wait; they are arbitrated in the next IDLE cycle.
- RR pointer wrap: after granting NUM_REQ-1 the pointer becomes 0.
- Fairness: each continuously requesting requester is granted at least once every NUM_REQ grants.
- Width rules: ptr and last_grant are $clog2(NUM_REQ) bits. counter is $clog2(HOLD_CYCLES+1) bits, minimum 1.

Test Plan:
- Reset with rst=1 for 2 cycles, req=4'hF asserted -> gpo_out=8'h00, ack=0, busy=0, last_grant=0; no grant while rst=1.
- req[0]=1, wr_data[0]=8'hA5, wr_mask[0]=8'hFF, requester drops req on ack -> in the cycle after the sampling edge: gpo_out=8'hA5, ack=4'b0001 for exactly 1 cycle, busy high for 2 cycles, last_grant=0.
- Masked write: from gpo_out=8'hA5, req[2] with data=8'h0F, mask=8'hF0 -> gpo_out=8'h05, ack=4'b0100.
- req=4'hF held, each dropping its own bit on ack, pointer=0, HOLD_CYCLES=2 -> grants in order 0,1,2,3, acks spaced 3 cycles apart, final gpo_out = requester 3's data.
- Wrap: after a grant to 3, req[0] and req[3] asserted together -> requester 0 granted first, then 3; last_grant sequence 0,3.
- rst asserted in the first HOLD cycle of a grant writing 8'h3C -> next cycle gpo_out=8'h00, ack=0, busy=0. A still-held req is re-granted on the first IDLE edge after rst deasserts.
